// File: rtl/univ_cnt_pkg.sv
// rtl/univ_cnt_pkg.sv - shared types for the universal modulo counter
//
// Purpose : counting-mode and event-cause enums shared by univ_mod_cnt,
//           univ_cnt_next and the bench.
// Ports   : none (package).
package univ_cnt_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   typedef enum logic [1:0] {
      EVT_NONE  = 2'd0,
      EVT_WRAP  = 2'd1,
      EVT_CLIP  = 2'd2,
      EVT_RANGE = 2'd3
   } evt_cause_e;

endpackage

// File: rtl/univ_cnt_next.sv
// rtl/univ_cnt_next.sv - combinational next-count and event-cause logic
//
// Purpose : given the current count, step, limit, direction and mode,
//           produce the count for an enabled cycle and why it was bent.
// Ports   : q_i       current count
//           step_i    requested step magnitude
//           max_val_i inclusive upper limit
//           up_i      1 = count up, 0 = count down
//           mode_i    wrap or saturate
//           q_o       next count
//           cause_o   EVT_NONE / EVT_WRAP / EVT_CLIP / EVT_RANGE
module univ_cnt_next
   import univ_cnt_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] q_i,
   input  logic [N-1:0] step_i,
   input  logic [N-1:0] max_val_i,
   input  logic         up_i,
   input  cnt_mode_e    mode_i,
   output logic [N-1:0] q_o,
   output evt_cause_e   cause_o
);

   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] s_n;
   logic [N:0]   q_x;
   logic [N:0]   s_x;
   logic [N:0]   max_x;
   logic [N:0]   sum_x;
   logic [N-1:0] wrap_up;
   logic [N-1:0] wrap_dn;

   always_comb begin
      // Step never exceeds the range width, so one wrap is always enough.
      s_n   = (step_i > max_val_i) ? max_val_i : step_i;
      q_x   = {1'b0, q_i};
      s_x   = {1'b0, s_n};
      max_x = {1'b0, max_val_i};
      sum_x = q_x + s_x;
      // Wrapped results are always within 0..max_val, so modulo-2^N
      // arithmetic on N bits yields the exact value.
      wrap_up = q_i + s_n - max_val_i - ONE_N;
      wrap_dn = q_i + max_val_i + ONE_N - s_n;

      q_o     = q_i;
      cause_o = EVT_NONE;
      if (q_x > max_x) begin
         // Limit was lowered beneath the count: snap to the entry edge.
         q_o     = up_i ? '0 : max_val_i;
         cause_o = EVT_RANGE;
      end else if (up_i) begin
         if (sum_x <= max_x) begin
            q_o = sum_x[N-1:0];
         end else if (mode_i == CNT_SAT) begin
            q_o     = max_val_i;
            cause_o = EVT_CLIP;
         end else begin
            q_o     = wrap_up;
            cause_o = EVT_WRAP;
         end
      end else begin
         if (q_x >= s_x) begin
            q_o = q_i - s_n;
         end else if (mode_i == CNT_SAT) begin
            q_o     = '0;
            cause_o = EVT_CLIP;
         end else begin
            q_o     = wrap_dn;
            cause_o = EVT_WRAP;
         end
      end
   end

endmodule

// File: rtl/univ_mod_cnt.sv
// rtl/univ_mod_cnt.sv - up/down counter with programmable limit, step and wrap/saturate
//
// Purpose : count register, mode register and sticky/pulse event flags,
//           with priority syn_clr > load > en > hold.
// Ports   : clk, rst (async, active-high)
//           syn_clr   clears count and flags
//           load, d   load d, clipped to max_val
//           en, up    count enable and direction
//           step      step magnitude (clamped to max_val)
//           max_val   inclusive upper limit
//           mode_we, mode_in  mode register write (0 wrap, 1 saturate)
//           clr_ovf   clears ovf_sticky
//           q         current count
//           max_tick  q == max_val;  min_tick  q == 0
//           evt       last update wrapped or clipped
//           ovf_sticky any wrap/clip since last clear;  mode  current mode
module univ_mod_cnt
   import univ_cnt_pkg::*;
#(
   parameter int N           = 8,
   parameter bit SAT_DEFAULT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         syn_clr,
   input  logic         load,
   input  logic         en,
   input  logic         up,
   input  logic         mode_we,
   input  logic         mode_in,
   input  logic [N-1:0] step,
   input  logic [N-1:0] max_val,
   input  logic [N-1:0] d,
   input  logic         clr_ovf,
   output logic [N-1:0] q,
   output logic         max_tick,
   output logic         min_tick,
   output logic         evt,
   output logic         ovf_sticky,
   output logic         mode
);

   logic [N-1:0] q_q, q_d;
   logic         evt_q, evt_d;
   logic         sticky_q, sticky_d;
   cnt_mode_e    mode_q, mode_d;

   logic [N-1:0] nxt_q;
   evt_cause_e   nxt_cause;
   logic         load_clip;

   univ_cnt_next #(.N(N)) u_next (
      .q_i       (q_q),
      .step_i    (step),
      .max_val_i (max_val),
      .up_i      (up),
      .mode_i    (mode_q),
      .q_o       (nxt_q),
      .cause_o   (nxt_cause)
   );

   assign load_clip = (d > max_val);

   always_comb begin
      q_d      = q_q;
      evt_d    = 1'b0;
      // A new event in the same cycle overrides clr_ovf below.
      sticky_d = sticky_q & ~clr_ovf;
      if (syn_clr) begin
         q_d      = '0;
         sticky_d = 1'b0;
      end else if (load) begin
         if (load_clip) begin
            q_d      = max_val;
            evt_d    = 1'b1;
            sticky_d = 1'b1;
         end else begin
            q_d = d;
         end
      end else if (en) begin
         q_d = nxt_q;
         if (nxt_cause != EVT_NONE) begin
            evt_d    = 1'b1;
            sticky_d = 1'b1;
         end
      end
      mode_d = mode_we ? cnt_mode_e'(mode_in) : mode_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q      <= '0;
         evt_q    <= 1'b0;
         sticky_q <= 1'b0;
         mode_q   <= cnt_mode_e'(SAT_DEFAULT);
      end else begin
         q_q      <= q_d;
         evt_q    <= evt_d;
         sticky_q <= sticky_d;
         mode_q   <= mode_d;
      end
   end

   assign q          = q_q;
   assign evt        = evt_q;
   assign ovf_sticky = sticky_q;
   assign mode       = mode_q;
   assign max_tick   = (q_q == max_val);
   assign min_tick   = (q_q == '0);

endmodule

// File: tb/tb_univ_mod_cnt.sv
// tb/tb_univ_mod_cnt.sv - directed self-checking bench for univ_mod_cnt
module tb_univ_mod_cnt;
   import univ_cnt_pkg::*;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         syn_clr = 1'b0;
   logic         load = 1'b0;
   logic         en = 1'b0;
   logic         up = 1'b1;
   logic         mode_we = 1'b0;
   logic         mode_in = 1'b0;
   logic         clr_ovf = 1'b0;
   logic [N-1:0] step = 4'd1;
   logic [N-1:0] max_val = 4'd9;
   logic [N-1:0] d = 4'd0;
   logic [N-1:0] q;
   logic         max_tick, min_tick, evt, ovf_sticky, mode;

   int checks = 0;
   int errors = 0;

   univ_mod_cnt #(.N(N), .SAT_DEFAULT(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .syn_clr    (syn_clr),
      .load       (load),
      .en         (en),
      .up         (up),
      .mode_we    (mode_we),
      .mode_in    (mode_in),
      .step       (step),
      .max_val    (max_val),
      .d          (d),
      .clr_ovf    (clr_ovf),
      .q          (q),
      .max_tick   (max_tick),
      .min_tick   (min_tick),
      .evt        (evt),
      .ovf_sticky (ovf_sticky),
      .mode       (mode)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      syn_clr = 1'b0; load = 1'b0; en = 1'b0; mode_we = 1'b0; clr_ovf = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d exp 0", q); end
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL reset_evt: got %b exp 0", evt); end
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b exp 0", ovf_sticky); end
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b exp 0", mode); end
      checks++; if (min_tick !== 1'b1) begin errors++; $display("FAIL reset_min_tick: got %b exp 1", min_tick); end
      checks++; if (max_tick !== 1'b0) begin errors++; $display("FAIL reset_max_tick: got %b exp 0", max_tick); end
      max_val = 4'd0;
      #1;
      checks++; if (max_tick !== 1'b1) begin errors++; $display("FAIL reset_max_tick_max0: got %b exp 1", max_tick); end
      max_val = 4'd9;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_wrap_up();
      logic [N-1:0] exp_q;
      logic         exp_evt, exp_st;
      idle(); syn_clr = 1'b1; cyc(); idle();
      max_val = 4'd9; step = 4'd1; up = 1'b1; en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         exp_q   = 4'((i + 1) % 10);
         exp_evt = (i == 9);
         exp_st  = (i >= 9);
         checks++; if (q !== exp_q) begin errors++; $display("FAIL wrap_up_q[%0d]: got %0d exp %0d", i, q, exp_q); end
         checks++; if (evt !== exp_evt) begin errors++; $display("FAIL wrap_up_evt[%0d]: got %b exp %b", i, evt, exp_evt); end
         checks++; if (ovf_sticky !== exp_st) begin errors++; $display("FAIL wrap_up_sticky[%0d]: got %b exp %b", i, ovf_sticky, exp_st); end
         checks++; if (max_tick !== (exp_q == 4'd9)) begin errors++; $display("FAIL wrap_up_max_tick[%0d]: got %b exp %b", i, max_tick, exp_q == 4'd9); end
      end
      idle();
   endtask

   task automatic test_sat_down();
      idle(); syn_clr = 1'b1; mode_we = 1'b1; mode_in = CNT_SAT; cyc(); idle();
      checks++; if (mode !== 1'b1) begin errors++; $display("FAIL sat_mode: got %b exp 1", mode); end
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_clr_sticky: got %b exp 0", ovf_sticky); end
      load = 1'b1; d = 4'd6; cyc(); idle();
      en = 1'b1; up = 1'b0; step = 4'd4;
      cyc();
      checks++; if (q !== 4'd2) begin errors++; $display("FAIL sat_down_q1: got %0d exp 2", q); end
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL sat_down_evt1: got %b exp 0", evt); end
      cyc();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL sat_down_q2: got %0d exp 0", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL sat_down_evt2: got %b exp 1", evt); end
      checks++; if (min_tick !== 1'b1) begin errors++; $display("FAIL sat_down_min_tick: got %b exp 1", min_tick); end
      checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_down_sticky: got %b exp 1", ovf_sticky); end
      cyc();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL sat_down_q3: got %0d exp 0", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL sat_down_evt3: got %b exp 1", evt); end
      idle(); cyc();
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL sat_hold_evt: got %b exp 0", evt); end
   endtask

   task automatic test_load_clip();
      idle(); syn_clr = 1'b1; cyc(); idle();
      max_val = 4'd9; load = 1'b1; d = 4'd12; cyc(); idle();
      checks++; if (q !== 4'd9) begin errors++; $display("FAIL clip_q: got %0d exp 9", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL clip_evt: got %b exp 1", evt); end
      checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL clip_sticky: got %b exp 1", ovf_sticky); end
      checks++; if (max_tick !== 1'b1) begin errors++; $display("FAIL clip_max_tick: got %b exp 1", max_tick); end
      clr_ovf = 1'b1; cyc(); idle();
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL clr_ovf_sticky: got %b exp 0", ovf_sticky); end
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL clr_ovf_evt: got %b exp 0", evt); end
      // set beats clear in the same cycle
      load = 1'b1; d = 4'd12; clr_ovf = 1'b1; cyc(); idle();
      checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL set_over_clr_sticky: got %b exp 1", ovf_sticky); end
      clr_ovf = 1'b1; cyc(); idle();
      // d == max_val is legal, no clip
      load = 1'b1; d = 4'd9; cyc(); idle();
      checks++; if (q !== 4'd9) begin errors++; $display("FAIL load_edge_q: got %0d exp 9", q); end
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL load_edge_evt: got %b exp 0", evt); end
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL load_edge_sticky: got %b exp 0", ovf_sticky); end
   endtask

   task automatic test_out_of_range();
      idle(); max_val = 4'd9; load = 1'b1; d = 4'd8; cyc(); idle();
      max_val = 4'd5;
      #1;
      checks++; if (max_tick !== 1'b0) begin errors++; $display("FAIL oor_max_tick0: got %b exp 0", max_tick); end
      en = 1'b1; up = 1'b1; step = 4'd1; cyc(); idle();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL oor_up_q: got %0d exp 0", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL oor_up_evt: got %b exp 1", evt); end
      max_val = 4'd9; load = 1'b1; d = 4'd8; cyc(); idle();
      max_val = 4'd5; en = 1'b1; up = 1'b0; cyc(); idle();
      checks++; if (q !== 4'd5) begin errors++; $display("FAIL oor_down_q: got %0d exp 5", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL oor_down_evt: got %b exp 1", evt); end
      checks++; if (max_tick !== 1'b1) begin errors++; $display("FAIL oor_down_max_tick: got %b exp 1", max_tick); end
      max_val = 4'd9;
   endtask

   task automatic test_priority();
      idle(); load = 1'b1; d = 4'd12; cyc(); idle();
      syn_clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; step = 4'd1; d = 4'd3; cyc(); idle();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL prio_clr_q: got %0d exp 0", q); end
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL prio_clr_evt: got %b exp 0", evt); end
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL prio_clr_sticky: got %b exp 0", ovf_sticky); end
      load = 1'b1; en = 1'b1; d = 4'd3; cyc(); idle();
      checks++; if (q !== 4'd3) begin errors++; $display("FAIL prio_load_q: got %0d exp 3", q); end
   endtask

   task automatic test_back_to_back();
      idle(); syn_clr = 1'b1; mode_we = 1'b1; mode_in = CNT_WRAP; cyc(); idle();
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL b2b_mode_wrap: got %b exp 0", mode); end
      max_val = 4'd9; load = 1'b1; d = 4'd3; cyc(); idle();
      // step 15 is clamped to 9
      en = 1'b1; up = 1'b1; step = 4'd15; cyc();
      checks++; if (q !== 4'd2) begin errors++; $display("FAIL b2b_wrap_q1: got %0d exp 2", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL b2b_wrap_evt1: got %b exp 1", evt); end
      cyc();
      checks++; if (q !== 4'd1) begin errors++; $display("FAIL b2b_wrap_q2: got %0d exp 1", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL b2b_wrap_evt2: got %b exp 1", evt); end
      up = 1'b0; step = 4'd3; cyc(); idle();
      checks++; if (q !== 4'd8) begin errors++; $display("FAIL wrap_down_q: got %0d exp 8", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL wrap_down_evt: got %b exp 1", evt); end
      mode_we = 1'b1; mode_in = CNT_SAT; load = 1'b1; d = 4'd9; cyc(); idle();
      en = 1'b1; up = 1'b1; step = 4'd2; cyc();
      checks++; if (q !== 4'd9) begin errors++; $display("FAIL sat_top_q1: got %0d exp 9", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL sat_top_evt1: got %b exp 1", evt); end
      cyc(); idle();
      checks++; if (q !== 4'd9) begin errors++; $display("FAIL sat_top_q2: got %0d exp 9", q); end
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL sat_top_evt2: got %b exp 1", evt); end
      max_val = 4'd0; load = 1'b1; d = 4'd0; cyc(); idle();
      en = 1'b1; step = 4'd5; cyc(); idle();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL max0_q: got %0d exp 0", q); end
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL max0_evt: got %b exp 0", evt); end
      checks++; if (max_tick !== 1'b1) begin errors++; $display("FAIL max0_max_tick: got %b exp 1", max_tick); end
      max_val = 4'd9; load = 1'b1; d = 4'd4; cyc(); idle();
      en = 1'b1; step = 4'd0; cyc(); idle();
      checks++; if (q !== 4'd4) begin errors++; $display("FAIL step0_q: got %0d exp 4", q); end
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL step0_evt: got %b exp 0", evt); end
   endtask

   task automatic test_async_reset();
      idle(); mode_we = 1'b1; mode_in = CNT_SAT; load = 1'b1; d = 4'd12; cyc(); idle();
      load = 1'b1; d = 4'd6; cyc(); idle();
      en = 1'b1; up = 1'b1; step = 4'd1; cyc();
      checks++; if (q !== 4'd7) begin errors++; $display("FAIL pre_rst_q: got %0d exp 7", q); end
      #2 rst = 1'b1;
      #1;
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL async_rst_q: got %0d exp 0", q); end
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL async_rst_evt: got %b exp 0", evt); end
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL async_rst_sticky: got %b exp 0", ovf_sticky); end
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL async_rst_mode: got %b exp 0", mode); end
      idle();
      @(negedge clk);
      rst = 1'b0;
      cyc();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL post_rst_q: got %0d exp 0", q); end
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_sat_down();
      test_load_clip();
      test_out_of_range();
      test_priority();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
